// File: rtl/ysyx_22040386_inst_queue.sv
// rtl/ysyx_22040386_inst_queue.sv - fetch-to-decode instruction FIFO with flush
module ysyx_22040386_inst_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_IQ_clk,
    input  logic          i_IQ_rst_n,
    input  logic          i_IQ_flush,
    input  logic          i_IQ_in_valid,
    output logic          o_IQ_in_ready,
    input  logic [63:0]   i_IQ_pc,
    input  logic [31:0]   i_IQ_inst,
    output logic          o_IQ_out_valid,
    input  logic          i_IQ_out_ready,
    output logic [63:0]   o_IQ_pc,
    output logic [31:0]   o_IQ_inst,
    output logic [AW:0]   o_IQ_count
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [95:0] mem_q [DEPTH];
    logic [AW:0] wp_q, wp_d;
    logic [AW:0] rp_q, rp_d;
    logic        empty, full, push, pop;
    logic [95:0] head;

    always_comb begin
        empty = (wp_q == rp_q);
        full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        push  = i_IQ_in_valid && !full;
        pop   = !empty && i_IQ_out_ready;
        wp_d  = wp_q;
        rp_d  = rp_q;
        // A redirect discards whatever handshakes happened in the same cycle.
        if (i_IQ_flush) begin
            wp_d = '0;
            rp_d = '0;
        end else begin
            if (push) wp_d = wp_q + PTR_ONE;
            if (pop)  rp_d = rp_q + PTR_ONE;
        end
    end

    always_ff @(posedge i_IQ_clk or negedge i_IQ_rst_n) begin
        if (!i_IQ_rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Entry storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge i_IQ_clk) begin
        if (push && !i_IQ_flush) begin
            mem_q[wp_q[AW-1:0]] <= {i_IQ_pc, i_IQ_inst};
        end
    end

    always_comb begin
        head           = mem_q[rp_q[AW-1:0]];
        o_IQ_in_ready  = !full;
        o_IQ_out_valid = !empty;
        o_IQ_count     = wp_q - rp_q;
        o_IQ_pc        = empty ? 64'd0 : head[95:32];
        o_IQ_inst      = empty ? 32'd0 : head[31:0];
    end

endmodule
